spi_slave_rx: RTL

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync.sv | 24 ++
 rtl/spi_slave_rx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: receiver FSM states and default frame width.
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer for a single asynchronous bit with a reset level.
module spi_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk) begin
        if (rst) begin
            ff <= {N{RST_VAL}};
        end else begin
            ff <= {ff[N-2:0], d};
        end
    end

    assign q = ff[N-1];

endmodule

// File: rtl/spi_slave_rx.sv
// Mode-0 SPI receive-only slave with a one-deep holding register
// and valid/ready output handshake.
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  CS,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam int CNT_W  = $clog2(DATA_WIDTH + 1);
    localparam int WARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(SYNC_STAGES);

    logic sclk_s, mosi_s, cs_s;
    logic sclk_q, cs_q;
    logic sclk_rise, cs_rise, cs_fall;

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
        .clk (clk),
        .rst (rst),
        .d   (SCLK),
        .q   (sclk_s)
    );

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .d   (MOSI),
        .q   (mosi_s)
    );

    spi_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk (clk),
        .rst (rst),
        .d   (CS),
        .q   (cs_s)
    );

    assign sclk_rise = sclk_s & ~sclk_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = ~cs_s & cs_q;

    spi_state_t            state, next_state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] frame;
    logic [WARM_W-1:0]     warm;
    logic                  armed;
    logic                  start, sample, complete, err, load;

    // A CS low seen straight out of reset is not a frame start; the
    // receiver only arms after CS has genuinely been observed high.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm  <= '0;
            armed <= 1'b0;
        end else begin
            if (warm != WARM_MAX) begin
                warm <= warm + 1'b1;
            end
            if (warm == WARM_MAX && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sclk_q <= 1'b1;
            cs_q   <= 1'b1;
        end else begin
            state  <= next_state;
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        sample     = 1'b0;
        complete   = 1'b0;
        err        = 1'b0;
        unique case (state)
            IDLE: begin
                if (cs_fall && armed) begin
                    next_state = RECV;
                    start      = 1'b1;
                end
            end
            RECV: begin
                if (sclk_rise) begin
                    sample   = 1'b1;
                    complete = (bit_cnt == LAST_BIT);
                end
                // A final sample coinciding with CS rise still counts.
                if (complete) begin
                    next_state = cs_rise ? IDLE : HOLD;
                end else if (cs_rise) begin
                    next_state = IDLE;
                    err        = 1'b1;
                end
            end
            HOLD: begin
                if (cs_rise) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign frame = {shift_reg[DATA_WIDTH-2:0], mosi_s};
    assign load  = complete && (!rx_valid || rx_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (start) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (sample) begin
                bit_cnt   <= bit_cnt + 1'b1;
                shift_reg <= frame;
            end
            if (load) begin
                rx_data  <= frame;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            overflow  <= complete && rx_valid && !rx_ready;
            frame_err <= err;
        end
    end

endmodule
